// File: rtl/sqr_acc_pipe.sv
// sqr_acc_pipe: pipelined squarer with valid/ready flow control, runtime
// signed/unsigned operand mode and a sum-of-squares accumulator.
// Datapath: magnitude -> partial products -> carry-save chain -> final adder.
module sqr_acc_pipe #(
  parameter int width    = 8,
  parameter int stages   = 2,
  parameter int accWidth = 2*width+8,
  parameter int speed    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IV,
  output logic                  IR,
  input  logic [width-1:0]      X,
  input  logic                  SGN,
  input  logic                  ACC,
  input  logic                  CLR,
  output logic                  OV,
  input  logic                  OR,
  output logic [2*width-1:0]    P,
  output logic [accWidth-1:0]   S,
  output logic                  OVF
);

  localparam int PW = 2*width;

  typedef struct packed {
    logic acc;
    logic clr;
  } meta_t;

  typedef logic [width-1:0][PW-1:0] pp_t;

  logic              advance;
  logic [stages:1]   vld_q;
  logic [stages:0]   vld_pipe;

  assign advance  = ~OV | OR;
  assign IR       = advance;
  assign OV       = vld_q[stages];
  assign vld_pipe = {vld_q, IV};

  // ---------------- input: extend, take magnitude, form partial products
  logic [width:0]    xe;
  logic [width-1:0]  mag;
  pp_t               pp_in;
  meta_t             m_in;

  // Squaring is sign-insensitive, so square |xe|; it always fits in width bits
  // (max 2^w-1 unsigned, 2^(w-1) signed).
  assign xe   = SGN ? {X[width-1], X} : {1'b0, X};
  assign mag  = xe[width] ? (~xe[width-1:0] + width'(1)) : xe[width-1:0];
  assign m_in = '{acc: ACC, clr: CLR};

  // Row i is mag gated by bit i, shifted into place.
  always_comb begin
    for (int i = 0; i < width; i++)
      pp_in[i] = PW'(mag & {width{mag[i]}}) << i;
  end

  // ---------------- optional partial-product register
  pp_t   pp_b;
  meta_t m_b;

  generate
    if (stages == 3) begin : g_pp_reg
      pp_t   pp_q;
      meta_t m1_q;
      // Partial products and their sample's controls move together on advance.
      always_ff @(posedge CLK) begin
        if (advance) begin
          pp_q <= pp_in;
          m1_q <= m_in;
        end
      end
      assign pp_b = pp_q;
      assign m_b  = m1_q;
    end else begin : g_pp_comb
      assign pp_b = pp_in;
      assign m_b  = m_in;
    end
  endgenerate

  // ---------------- carry-save chain: folds one row per 3:2 compressor
  logic [PW-1:0] cs_s [width];
  logic [PW-1:0] cs_c [width];

  assign cs_s[0] = pp_b[0];
  assign cs_c[0] = '0;

  generate
    for (genvar i = 1; i < width; i++) begin : g_csa
      logic [PW-1:0] maj;
      assign cs_s[i] = cs_s[i-1] ^ cs_c[i-1] ^ pp_b[i];
      assign maj     = (cs_s[i-1] & cs_c[i-1]) | (cs_s[i-1] & pp_b[i]) |
                       (cs_c[i-1] & pp_b[i]);
      // Carry out of the top bit is dropped: the exact square fits in PW bits.
      assign cs_c[i] = maj << 1;
    end
  endgenerate

  // ---------------- optional sum/carry register
  logic [PW-1:0] s_f, c_f;
  meta_t         m_f;

  generate
    if (stages >= 2) begin : g_sc_reg
      logic [PW-1:0] s_q, c_q;
      meta_t         m2_q;
      // Redundant sum/carry pair plus controls, held while stalled.
      always_ff @(posedge CLK) begin
        if (advance) begin
          s_q  <= cs_s[width-1];
          c_q  <= cs_c[width-1];
          m2_q <= m_b;
        end
      end
      assign s_f = s_q;
      assign c_f = c_q;
      assign m_f = m2_q;
    end else begin : g_sc_comb
      assign s_f = cs_s[width-1];
      assign c_f = cs_c[width-1];
      assign m_f = m_b;
    end
  endgenerate

  // ---------------- final carry-propagate adder
  logic [PW-1:0] pfin;

  generate
    if (speed > 0) begin : g_fa_fast
      assign pfin = s_f + c_f;
    end else begin : g_fa_ripple
      // Explicit bit-serial ripple carry resolving the sum/carry pair.
      always_comb begin
        logic cy;
        cy   = 1'b0;
        pfin = '0;
        for (int i = 0; i < PW; i++) begin
          pfin[i] = s_f[i] ^ c_f[i] ^ cy;
          cy      = (s_f[i] & c_f[i]) | (s_f[i] & cy) | (c_f[i] & cy);
        end
      end
    end
  endgenerate

  // ---------------- output register and accumulator
  logic              load;
  logic [accWidth:0] acc_sum;

  assign load    = advance & vld_pipe[stages-1];
  assign acc_sum = {1'b0, S} + (accWidth+1)'(pfin);

  // Valid bits shift with the data; P/S/OVF update only when a real sample
  // enters the output register, so they hold through stalls and bubbles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      P     <= '0;
      S     <= '0;
      OVF   <= 1'b0;
    end else if (advance) begin
      vld_q <= vld_pipe[stages-1:0];
      if (load) begin
        P <= pfin;
        case ({m_f.clr, m_f.acc})
          2'b11: begin S <= accWidth'(pfin);          OVF <= 1'b0; end
          2'b10: begin S <= '0;                       OVF <= 1'b0; end
          2'b01: begin S <= acc_sum[accWidth-1:0];    OVF <= OVF | acc_sum[accWidth]; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqr_acc_pipe.sv
// tb_sqr_acc_pipe: directed scenarios for sqr_acc_pipe at width=8, stages=2,
// accWidth=24. Inputs change and outputs are sampled on the falling edge.
module tb_sqr_acc_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IV  = 1'b0;
  logic        IR;
  logic [7:0]  X   = '0;
  logic        SGN = 1'b0;
  logic        ACC = 1'b0;
  logic        CLR = 1'b0;
  logic        OV;
  logic        OR  = 1'b1;
  logic [15:0] P;
  logic [23:0] S;
  logic        OVF;

  int nchk  = 0;
  int nfail = 0;

  sqr_acc_pipe #(.width(8), .stages(2), .accWidth(24), .speed(0)) dut (
    .CLK(CLK), .RST(RST), .IV(IV), .IR(IR), .X(X), .SGN(SGN), .ACC(ACC),
    .CLR(CLR), .OV(OV), .OR(OR), .P(P), .S(S), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic iv, input logic [7:0] x, input logic sgn,
                       input logic acc, input logic clr);
    IV = iv; X = x; SGN = sgn; ACC = acc; CLR = clr;
  endtask

  // Present one sample for one cycle, then wait (bounded) for OV.
  task automatic run_one(input logic [7:0] x, input logic sgn, input logic acc,
                         input logic clr, output bit ok);
    ok = 1'b0;
    drive(1'b1, x, sgn, acc, clr);
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (OV === 1'b1) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; OR = 1'b1;
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    nchk++; if (OV !== 1'b0)   begin nfail++; $display("FAIL reset_ov: got %b required 0", OV); end
    nchk++; if (P !== 16'h0)   begin nfail++; $display("FAIL reset_p: got %h required 0000", P); end
    nchk++; if (S !== 24'h0)   begin nfail++; $display("FAIL reset_s: got %0d required 0", S); end
    nchk++; if (OVF !== 1'b0)  begin nfail++; $display("FAIL reset_ovf: got %b required 0", OVF); end
    nchk++; if (IR !== 1'b1)   begin nfail++; $display("FAIL reset_ir: got %b required 1", IR); end
    @(negedge CLK);
  endtask

  task automatic test_unsigned;
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nchk++; if (OV !== 1'b0) begin nfail++; $display("FAIL uns_latency1: OV got %b required 0", OV); end
    @(negedge CLK);
    nchk++; if (OV !== 1'b1) begin nfail++; $display("FAIL uns_latency2: OV got %b required 1", OV); end
    nchk++; if (P !== 16'hFE01) begin nfail++; $display("FAIL uns_ff: P got %h required fe01", P); end
    @(negedge CLK);
  endtask

  task automatic test_signed;
    logic [7:0]  xs [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [15:0] ps [3] = '{16'h4000, 16'h0001, 16'h3F01};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      run_one(xs[k], 1'b1, 1'b0, 1'b0, ok);
      nchk++; if (!ok) begin nfail++; $display("FAIL sgn_timeout x=%h: OV got 0 required 1", xs[k]); end
      nchk++; if (P !== ps[k]) begin nfail++; $display("FAIL sgn_p x=%h: P got %h required %h", xs[k], P, ps[k]); end
    end
    @(negedge CLK);
    // Full sweep in both modes, streamed back to back.
    for (int m = 0; m < 2; m++) begin
      logic [15:0] q [$];
      int sent = 0, got = 0, cyc = 0;
      while (got < 256 && cyc < 600) begin
        logic [7:0] xv;
        int v;
        if (OV === 1'b1) begin
          nchk++;
          if (q.size() == 0 || P !== q[0]) begin
            nfail++;
            $display("FAIL sweep m=%0d idx=%0d: P got %h required %h", m, got, P, (q.size() != 0) ? q[0] : 16'hxxxx);
          end
          if (q.size() != 0) void'(q.pop_front());
          got++;
        end
        if (sent < 256) begin
          xv = 8'(sent);
          v  = (m == 1) ? int'($signed(xv)) : int'(xv);
          drive(1'b1, xv, (m == 1), 1'b0, 1'b0);
          q.push_back(16'(v * v));
          sent++;
        end else begin
          drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        @(negedge CLK);
        cyc++;
      end
      nchk++; if (got != 256) begin nfail++; $display("FAIL sweep_count m=%0d: got %0d required 256", m, got); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_backpressure;
    int nxt = 0, got = 0, stall = -1, gaps = 0;
    bit accepted;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (stall < 0 && OV === 1'b1) stall = 4;
      OR = (stall > 0) ? 1'b0 : 1'b1;
      if (nxt < 6) drive(1'b1, 8'(nxt + 1), 1'b0, 1'b0, 1'b0);
      else         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      if (stall > 0) begin
        nchk++; if (IR !== 1'b0) begin nfail++; $display("FAIL bp_ir cyc=%0d: got %b required 0", cyc, IR); end
        nchk++; if (OV !== 1'b1 || P !== 16'h0001) begin
          nfail++; $display("FAIL bp_hold cyc=%0d: OV/P got %b/%h required 1/0001", cyc, OV, P);
        end
        stall--;
      end else if (stall == 0) begin
        if (OV === 1'b1) begin
          nchk++;
          if (P !== 16'((got + 1) * (got + 1))) begin
            nfail++; $display("FAIL bp_order idx=%0d: P got %h required %h", got, P, 16'((got + 1) * (got + 1)));
          end
          got++;
        end else begin
          gaps++;
        end
      end
      accepted = (IV === 1'b1) && (IR === 1'b1);
      @(negedge CLK);
      if (accepted) nxt++;
    end
    OR = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nchk++; if (got != 6)  begin nfail++; $display("FAIL bp_count: got %0d required 6", got); end
    nchk++; if (gaps != 0) begin nfail++; $display("FAIL bp_gaps: got %0d required 0", gaps); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_accum;
    logic [7:0]  xs  [5] = '{8'h03, 8'h04, 8'hFB, 8'h02, 8'h01};
    logic        ac  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        cl  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [23:0] es  [5] = '{24'd9, 24'd25, 24'd50, 24'd50, 24'd0};
    logic [15:0] ep  [5] = '{16'd9, 16'd16, 16'd25, 16'd4, 16'd1};
    bit ok;
    for (int k = 0; k < 5; k++) begin
      run_one(xs[k], 1'b1, ac[k], cl[k], ok);
      nchk++; if (!ok) begin nfail++; $display("FAIL acc_timeout k=%0d: OV got 0 required 1", k); end
      nchk++; if (S !== es[k]) begin nfail++; $display("FAIL acc_s k=%0d: S got %0d required %0d", k, S, es[k]); end
      nchk++; if (P !== ep[k]) begin nfail++; $display("FAIL acc_p k=%0d: P got %0d required %0d", k, P, ep[k]); end
    end
    @(negedge CLK);
  endtask

  task automatic test_overflow;
    int sent = 0, got = 0;
    bit ok;
    for (int cyc = 0; cyc < 400 && got < 259; cyc++) begin
      if (OV === 1'b1) begin
        got++;
        if (got == 258) begin
          nchk++; if (S !== 24'd16776450) begin nfail++; $display("FAIL ovf_s258: S got %0d required 16776450", S); end
          nchk++; if (OVF !== 1'b0) begin nfail++; $display("FAIL ovf_f258: OVF got %b required 0", OVF); end
        end
        if (got == 259) begin
          nchk++; if (S !== 24'd64259) begin nfail++; $display("FAIL ovf_s259: S got %0d required 64259", S); end
          nchk++; if (OVF !== 1'b1) begin nfail++; $display("FAIL ovf_f259: OVF got %b required 1", OVF); end
        end
      end
      if (sent < 259) begin
        drive(1'b1, 8'hFF, 1'b0, 1'b1, (sent == 0));
        sent++;
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      @(negedge CLK);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nchk++; if (got != 259) begin nfail++; $display("FAIL ovf_count: got %0d required 259", got); end
    repeat (4) @(negedge CLK);
    nchk++; if (OVF !== 1'b1) begin nfail++; $display("FAIL ovf_sticky: OVF got %b required 1", OVF); end
    run_one(8'h02, 1'b0, 1'b1, 1'b1, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL ovf_clr_timeout: OV got 0 required 1"); end
    nchk++; if (S !== 24'd4) begin nfail++; $display("FAIL ovf_clr_s: S got %0d required 4", S); end
    nchk++; if (OVF !== 1'b0) begin nfail++; $display("FAIL ovf_clr_f: OVF got %b required 0", OVF); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    OR = 1'b1;
    drive(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    drive(1'b1, 8'h06, 1'b1, 1'b1, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
    #1;
    nchk++; if (IR !== 1'b1)  begin nfail++; $display("FAIL rm_ir: got %b required 1", IR); end
    nchk++; if (OV !== 1'b0)  begin nfail++; $display("FAIL rm_ov: got %b required 0", OV); end
    nchk++; if (S !== 24'd0)  begin nfail++; $display("FAIL rm_s: got %0d required 0", S); end
    nchk++; if (OVF !== 1'b0) begin nfail++; $display("FAIL rm_ovf: got %b required 0", OVF); end
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nchk++; if (OV !== 1'b0) begin nfail++; $display("FAIL rm_ghost1: OV got %b required 0", OV); end
    @(negedge CLK);
    nchk++; if (OV !== 1'b1 || P !== 16'd49) begin
      nfail++; $display("FAIL rm_new: OV/P got %b/%0d required 1/49", OV, P);
    end
    nchk++; if (S !== 24'd49) begin nfail++; $display("FAIL rm_new_s: S got %0d required 49", S); end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      nchk++; if (OV !== 1'b0) begin nfail++; $display("FAIL rm_ghost cyc=%0d: OV got %b required 0", i, OV); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_accum();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
